// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// datapath mux selects and the packed control vector.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EX   = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> datapath control vector decode.
// JUMP outputs exist only when MULTICYCLE_JUMP_EN is defined.
module mc_output_decode
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      // FETCH loads PC and IR only once memory delivers the word.
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_write  = mem_ready;
        ctrl.ir_write  = mem_ready;
      end
      S_DECODE:    ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB:   ctrl.reg_write = 1'b1;
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: state/opcode registers, retire counter and
// sticky illegal-opcode flag. Define MULTICYCLE_JUMP_EN to decode opcode 2 as JUMP.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state;
  logic [5:0] opcode_q;
  logic       illegal_q;
  ctrl_t      ctrl;
  ctrl_t      ctrl_gated;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      opcode_q    <= '0;
      instr_count <= '0;
      illegal_q   <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          opcode_q <= opcode;
          case (opcode)
            OP_LW, OP_SW: state <= S_MEM_ADDR;
            OP_RTYPE:     state <= S_EXECUTE;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDI_EX;
`ifdef MULTICYCLE_JUMP_EN
            OP_J:         state <= S_JUMP;
`endif
            default: begin
              state     <= S_TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        // Only lw/sw reach MEM_ADDR, so anything but lw is a store.
        S_MEM_ADDR: state <= (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ: if (mem_ready) state <= S_MEM_WB;
        S_MEM_WRITE: begin
          if (mem_ready) begin
            state       <= S_FETCH;
            instr_count <= instr_count + CNT_W'(1);
          end
        end
        S_EXECUTE:  state <= S_ALU_WB;
        S_ADDI_EX:  state <= S_ADDI_WB;
`ifdef MULTICYCLE_JUMP_EN
        S_MEM_WB, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP: begin
`else
        S_MEM_WB, S_ALU_WB, S_BRANCH, S_ADDI_WB: begin
`endif
          state       <= S_FETCH;
          instr_count <= instr_count + CNT_W'(1);
        end
        S_TRAP: ;
        default: begin
          state     <= S_TRAP;
          illegal_q <= 1'b1;
        end
      endcase
    end
  end

  mc_output_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Reset kills every strobe immediately so an aborted access leaves no partial pulse.
  assign ctrl_gated = reset ? ctrl : '0;

  assign pc_write      = ctrl_gated.pc_write;
  assign pc_write_cond = ctrl_gated.pc_write_cond;
  assign ir_write      = ctrl_gated.ir_write;
  assign i_or_d        = ctrl_gated.i_or_d;
  assign mem_read      = ctrl_gated.mem_read;
  assign mem_write     = ctrl_gated.mem_write;
  assign mem_to_reg    = ctrl_gated.mem_to_reg;
  assign reg_dst       = ctrl_gated.reg_dst;
  assign reg_write     = ctrl_gated.reg_write;
  assign alu_src_a     = ctrl_gated.alu_src_a;
  assign alu_src_b     = ctrl_gated.alu_src_b;
  assign alu_op        = ctrl_gated.alu_op;
  assign pc_source     = ctrl_gated.pc_source;
  assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected per-cycle control vectors are
// queued as stimulus is planned, then popped and compared mid-cycle.
module tb_multicycle_ctrl;

  localparam int CNT_W = 3;
  localparam logic [5:0] JUNK = 6'h3F;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [5:0]       opcode = '0;
  logic             mem_ready = 1'b0;
  logic             pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [CNT_W-1:0] instr_count;
  logic [16:0]      obs_vec;

  typedef struct {
    string            st;
    logic             mr;
    logic [5:0]       op;
    logic [16:0]      vec;
    logic [CNT_W-1:0] cnt;
  } item_t;

  item_t            sb[$];
  item_t            it;
  logic [CNT_W-1:0] model_count = '0;
  int               n_cmp = 0;
  int               n_err = 0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs_vec = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, illegal_op};

  // Expected outputs per state, straight from the control table.
  function automatic logic [16:0] spec_vec(input string st, input logic mr);
    logic pw, pwc, irw, iod, mrd, mwr, m2r, rdst, rw, srca, ill;
    logic [1:0] srcb, aop, psrc;
    {pw, pwc, irw, iod, mrd, mwr, m2r, rdst, rw, srca, ill} = '0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      "FETCH":     begin mrd = 1; srcb = 2'b01; pw = mr; irw = mr; end
      "DECODE":    srcb = 2'b11;
      "MEM_ADDR":  begin srca = 1; srcb = 2'b10; end
      "MEM_READ":  begin mrd = 1; iod = 1; end
      "MEM_WB":    begin m2r = 1; rw = 1; end
      "MEM_WRITE": begin mwr = 1; iod = 1; end
      "EXECUTE":   begin srca = 1; aop = 2'b10; end
      "ALU_WB":    begin rdst = 1; rw = 1; end
      "BRANCH":    begin srca = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      "ADDI_EX":   begin srca = 1; srcb = 2'b10; end
      "ADDI_WB":   rw = 1;
      "JUMP":      begin pw = 1; psrc = 2'b10; end
      "TRAP":      ill = 1;
      default: ;
    endcase
    return {pw, pwc, irw, iod, mrd, mwr, m2r, rdst, rw, srca, srcb, aop, psrc, ill};
  endfunction

  task automatic push(input string st, input logic mr, input logic [5:0] op);
    item_t e;
    e.st = st; e.mr = mr; e.op = op;
    e.vec = spec_vec(st, mr);
    e.cnt = model_count;
    sb.push_back(e);
    if (st == "MEM_WB" || st == "ALU_WB" || st == "BRANCH" || st == "ADDI_WB" ||
        st == "JUMP" || (st == "MEM_WRITE" && mr))
      model_count = model_count + 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_count = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'd35;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== 17'd0) begin
        n_err++;
        $display("[TB] FAIL reset_ctrl got %b want %b", obs_vec, 17'd0);
      end
      n_cmp++;
      if (instr_count !== '0) begin
        n_err++;
        $display("[TB] FAIL reset_count got %0d want 0", instr_count);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_count = '0;
  endtask

  task automatic test_lw();
    push("FETCH", 1, JUNK);
    push("DECODE", 1, 6'(32'h8D0B0000 >> 26));
    push("MEM_ADDR", 1, JUNK);
    push("MEM_READ", 1, 6'd4);
    push("MEM_WB", 1, JUNK);
    push("FETCH", 0, JUNK);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr; opcode = it.op;
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== it.vec) begin
        n_err++;
        $display("[TB] FAIL lw_%s ctrl got %b want %b", it.st, obs_vec, it.vec);
      end
      n_cmp++;
      if (instr_count !== it.cnt) begin
        n_err++;
        $display("[TB] FAIL lw_%s count got %0d want %0d", it.st, instr_count, it.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_stall();
    push("FETCH", 1, JUNK);
    push("DECODE", 1, 6'd43);
    push("MEM_ADDR", 1, 6'd35);
    push("MEM_WRITE", 0, JUNK);
    push("MEM_WRITE", 0, JUNK);
    push("MEM_WRITE", 0, JUNK);
    push("MEM_WRITE", 1, JUNK);
    push("FETCH", 0, JUNK);
    push("FETCH", 0, JUNK);
    push("FETCH", 1, JUNK);
    push("DECODE", 0, 6'd8);
    push("ADDI_EX", 1, JUNK);
    push("ADDI_WB", 0, JUNK);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr; opcode = it.op;
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== it.vec) begin
        n_err++;
        $display("[TB] FAIL sw_%s ctrl got %b want %b", it.st, obs_vec, it.vec);
      end
      n_cmp++;
      if (instr_count !== it.cnt) begin
        n_err++;
        $display("[TB] FAIL sw_%s count got %0d want %0d", it.st, instr_count, it.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    push("FETCH", 1, JUNK);
    push("DECODE", 1, 6'(32'h02484020 >> 26));
    push("EXECUTE", 0, JUNK);
    push("ALU_WB", 0, JUNK);
    for (int i = 0; i < 5; i++) begin
      push("FETCH", 1, JUNK);
      push("DECODE", 0, 6'(32'h11600001 >> 26));
      push("BRANCH", 0, JUNK);
    end
    push("FETCH", 0, JUNK);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr; opcode = it.op;
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== it.vec) begin
        n_err++;
        $display("[TB] FAIL b2b_%s ctrl got %b want %b", it.st, obs_vec, it.vec);
      end
      n_cmp++;
      if (instr_count !== it.cnt) begin
        n_err++;
        $display("[TB] FAIL b2b_%s count got %0d want %0d", it.st, instr_count, it.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    push("FETCH", 1, JUNK);
    push("DECODE", 1, 6'd35);
    push("MEM_ADDR", 1, JUNK);
    push("MEM_READ", 0, JUNK);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr; opcode = it.op;
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== it.vec) begin
        n_err++;
        $display("[TB] FAIL midrst_%s ctrl got %b want %b", it.st, obs_vec, it.vec);
      end
      if (sb.size() > 0) begin
        @(posedge clk); #1;
      end
    end
    #2;
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (obs_vec !== 17'd0) begin
      n_err++;
      $display("[TB] FAIL midrst_abort ctrl got %b want %b", obs_vec, 17'd0);
    end
    n_cmp++;
    if (instr_count !== '0) begin
      n_err++;
      $display("[TB] FAIL midrst_abort count got %0d want 0", instr_count);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_count = '0;
    push("FETCH", 1, JUNK);
    push("DECODE", 1, 6'd0);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr; opcode = it.op;
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== it.vec) begin
        n_err++;
        $display("[TB] FAIL midrst_%s ctrl got %b want %b", it.st, obs_vec, it.vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    apply_reset();
    push("FETCH", 1, JUNK);
    push("DECODE", 1, 6'd2);
`ifdef MULTICYCLE_JUMP_EN
    push("JUMP", 0, JUNK);
    push("FETCH", 1, JUNK);
`else
    push("TRAP", 1, JUNK);
    push("TRAP", 0, JUNK);
`endif
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr; opcode = it.op;
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== it.vec) begin
        n_err++;
        $display("[TB] FAIL jump_%s ctrl got %b want %b", it.st, obs_vec, it.vec);
      end
      n_cmp++;
      if (instr_count !== it.cnt) begin
        n_err++;
        $display("[TB] FAIL jump_%s count got %0d want %0d", it.st, instr_count, it.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap();
    apply_reset();
    push("FETCH", 1, JUNK);
    push("DECODE", 1, 6'h3F);
    for (int i = 0; i < 20; i++) push("TRAP", 1'($urandom_range(0, 1)), 6'($urandom));
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.mr; opcode = it.op;
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== it.vec) begin
        n_err++;
        $display("[TB] FAIL trap_%s ctrl got %b want %b", it.st, obs_vec, it.vec);
      end
      n_cmp++;
      if (instr_count !== it.cnt) begin
        n_err++;
        $display("[TB] FAIL trap_%s count got %0d want %0d", it.st, instr_count, it.cnt);
      end
      @(posedge clk); #1;
    end
    apply_reset();
    mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs_vec !== spec_vec("FETCH", 1'b1)) begin
      n_err++;
      $display("[TB] FAIL trap_cleared ctrl got %b want %b", obs_vec, spec_vec("FETCH", 1'b1));
    end
    n_cmp++;
    if (instr_count !== '0) begin
      n_err++;
      $display("[TB] FAIL trap_cleared count got %0d want 0", instr_count);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_back_to_back();
    test_mid_reset();
    test_jump();
    test_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control sequencer for the multi-cycle MIPS datapath. It replaces the single-cycle opcode decoder with a Moore FSM that spreads each instruction over 3–5 cycles. This lets the datapath share one ALU and one unified memory port. The block sits between the instruction register's opcode field and every datapath enable/select. It also stalls on a memory ready handshake, flags illegal opcodes, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from IR; sampled in DECODE
- mem_ready  in  1  memory completed current access this cycle
- pc_write  out  1  load PC unconditionally
- pc_write_cond  out  1  load PC if ALU zero (datapath ANDs)
- ir_write  out  1  load instruction register
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- mem_to_reg  out  1  write-back: 0=ALUOut, 1=MDR
- reg_dst  out  1  dest reg: 0=rt, 1=rd
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  to Alu_Control: 00 add, 01 sub, 10 funct
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  out  1  sticky, undecodable opcode seen
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- Outputs not listed for a state are 0.
- FETCH: mem_read=1, alu_src_b=01. pc_write=ir_write=mem_ready. Stays in FETCH while mem_ready=0. Goes to DECODE on mem_ready=1.
- DECODE: alu_src_b=11. Next state is chosen by opcode:
  - 35 or 43 → MEM_ADDR
  - 0 → EXECUTE
  - 4 → BRANCH
  - 8 → ADDI_EX
  - 2 → JUMP (only when jump support is compiled in)
  - any other opcode → TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Goes to MEM_READ for opcode 35, MEM_WRITE for opcode 43.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: mem_to_reg=1, reg_write=1. Retires, goes to FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready=1, then retires and goes to FETCH.
- EXECUTE: alu_src_a=1, alu_op=10. Goes to ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1. Retires, goes to FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. Retires, goes to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10. Goes to ADDI_WB.
- ADDI_WB: reg_write=1. Retires, goes to FETCH.
- TRAP: illegal_op=1. All enables are 0. Absorbing state; only reset exits.
- Retiring means instr_count increments by 1 on the exit edge of that state. The counter wraps to 0 after its maximum value.
- opcode is sampled only in DECODE. Later states use the registered opcode copy, so IR changes after DECODE have no effect.

## Timing
- All outputs are Moore from the state register, except pc_write and ir_write in FETCH, which are gated by mem_ready (Mealy).
- Zero-stall latency (retire-to-next-FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Strobes stay asserted and stable during the stall.
- mem_ready is ignored in all other states.
- While reset=0:
  - state=FETCH, opcode register=0, instr_count=0, illegal_op=0.
  - All outputs are forced to 0, including mem_read and alu_src_b.
- The first fetch is issued on the first clk edge after reset is released.
- Reset asserted mid-instruction aborts it immediately, with no retire and no partial write-enable pulse.

## Configuration
- MULTICYCLE_JUMP_EN defined: opcode 2 decodes to JUMP. JUMP drives pc_write=1 and pc_source=10, retires, and goes to FETCH.
- MULTICYCLE_JUMP_EN undefined: opcode 2 goes to TRAP. pc_source never takes the value 10.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_ADDI=8, OP_LW=35, OP_SW=43)
  - the state enum encoding (FETCH=0 … TRAP, 4-bit)
  - alu_op, alu_src_b and pc_source encodings, also used by Alu_Control and the datapath muxes
- Sub-module mc_output_decode: combinational state → control-vector decode. The top level holds the state register, opcode register, counter and sticky flag.

## Test plan
- Reset release, mem_ready tied to 1, IR=0x8D0B0000 (lw) → states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. reg_write=1 with mem_to_reg=1 only in cycle 5; instr_count=1 afterwards.
- sw with mem_ready low for 3 cycles in MEM_WRITE → mem_write=1 and i_or_d=1 held for 4 cycles; retire occurs on the cycle mem_ready=1.
- R-type (0x02484020) followed by beq (0x11600001) → ALU_WB has reg_dst=1; BRANCH has pc_write_cond=1, pc_source=01, alu_op=01; instr_count=2 after 7 cycles.
- Opcode 0x3F → TRAP after DECODE. illegal_op=1 persists over 20 cycles with all enables 0; reset clears it and instr_count.
- Reset asserted during MEM_READ → mem_read drops in the same cycle, no reg_write pulse, FETCH after release.
- Opcode 2 with and without MULTICYCLE_JUMP_EN → JUMP (pc_write=1, pc_source=10, 3 cycles) versus TRAP.
